// File: rtl/antares_ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : antares_ex_muldiv_unit_if
//  Purpose  : EX-stage <-> multiply/divide unit signal bundle
//  Revision : 1.0  initial release
// ============================================================================
interface antares_ex_muldiv_unit_if;
    logic [31:0] ex_data_rs;
    logic [31:0] ex_data_rt;
    logic [3:0]  ex_md_op;
    logic        ex_flush;
    logic        ex_stall;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_stall;
    logic        md_busy;

    // Pipeline side: issues operands/opcodes, consumes HI/LO and the stall
    modport master (
        output ex_data_rs, ex_data_rt, ex_md_op, ex_flush, ex_stall,
        input  md_hi, md_lo, md_stall, md_busy
    );

    // Unit side
    modport slave (
        input  ex_data_rs, ex_data_rt, ex_md_op, ex_flush, ex_stall,
        output md_hi, md_lo, md_stall, md_busy
    );
endinterface
`default_nettype wire

// File: rtl/antares_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : antares_ex_muldiv_unit
//  Purpose  : EX-stage multiply/divide unit holding the HI/LO registers.
//             2-cycle multiply (with optional accumulate), 32-cycle restoring
//             divide plus a sign-fixup cycle.
//  Revision : 1.0  initial release
// ============================================================================
module antares_ex_muldiv_unit #(
    parameter bit ENABLE_MADD = 1'b1
) (
    input  wire                      clk,
    input  wire                      rst,
    antares_ex_muldiv_unit_if.slave  md_if
);
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_DIV  = 3'd3,
        S_DFIX = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_hi, r_lo;
    logic [32:0] r_op_a, r_op_b;     // multiply: extended operands; divide: quotient/dividend and divisor
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [5:0]  r_count;
    logic [3:0]  r_op;
    logic        r_neg_q, r_neg_r, r_busy;

    logic        w_is_mul, w_is_div, w_is_signed, w_start, w_stall;
    logic [31:0] w_abs_rs, w_abs_rt;
    logic [63:0] w_mul_a, w_mul_b, w_mul_result;
    logic [32:0] w_div_shift, w_div_diff;
    logic [31:0] w_div_rem, w_div_quo, w_quo_fix, w_rem_fix;

    // Opcode decode of the instruction sitting in EX
    always_comb begin
        w_is_mul    = 1'b0;
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
        case (md_if.ex_md_op)
            c_OP_MULT, c_OP_MADD, c_OP_MSUB: begin
                w_is_mul    = 1'b1;
                w_is_signed = 1'b1;
            end
            c_OP_MULTU, c_OP_MADDU, c_OP_MSUBU: w_is_mul = 1'b1;
            c_OP_DIV: begin
                w_is_div    = 1'b1;
                w_is_signed = 1'b1;
            end
            c_OP_DIVU: w_is_div = 1'b1;
            default: ;
        endcase
    end

    // A long op starts only from IDLE; flush and reset both veto it
    assign w_start  = rst && (r_state == S_IDLE) && (w_is_mul || w_is_div) && !md_if.ex_flush;
    assign w_abs_rs = (w_is_signed && md_if.ex_data_rs[31]) ? (32'd0 - md_if.ex_data_rs) : md_if.ex_data_rs;
    assign w_abs_rt = (w_is_signed && md_if.ex_data_rt[31]) ? (32'd0 - md_if.ex_data_rt) : md_if.ex_data_rt;

    // Only the low 64 bits of the 66-bit signed product matter, so a
    // 64x64 modulo-2^64 multiply of the sign-extended operands suffices.
    assign w_mul_a = {{31{r_op_a[32]}}, r_op_a};
    assign w_mul_b = {{31{r_op_b[32]}}, r_op_b};

    // Restoring divide step: shift in the next dividend bit, trial-subtract
    assign w_div_shift = {r_rem, r_op_a[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_op_b[31:0]};
    assign w_div_rem   = w_div_diff[32] ? w_div_shift[31:0] : w_div_diff[31:0];
    assign w_div_quo   = {r_op_a[30:0], ~w_div_diff[32]};
    assign w_quo_fix   = r_neg_q ? (32'd0 - r_op_a[31:0]) : r_op_a[31:0];
    assign w_rem_fix   = r_neg_r ? (32'd0 - r_rem) : r_rem;

    // Final HI/LO value for the multiply family
    always_comb begin
        w_mul_result = r_prod;
        if (ENABLE_MADD) begin
            case (r_op)
                c_OP_MADD, c_OP_MADDU: w_mul_result = {r_hi, r_lo} + r_prod;
                c_OP_MSUB, c_OP_MSUBU: w_mul_result = {r_hi, r_lo} - r_prod;
                default: ;
            endcase
        end
    end

    // Next-state and stall request
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) begin
                w_stall      = 1'b1;
                w_state_next = w_is_div ? S_DIV : S_MUL1;
            end
            S_MUL1: begin
                w_stall      = 1'b1;
                w_state_next = S_MUL2;
            end
            S_MUL2: begin
                w_stall      = 1'b1;
                w_state_next = S_DONE;
            end
            S_DIV: begin
                w_stall = 1'b1;
                if (r_count == 6'd0) w_state_next = S_DFIX;
            end
            S_DFIX: begin
                w_stall      = 1'b1;
                w_state_next = S_DONE;
            end
            // Wait here until EX moves on so the finished op is not re-issued
            S_DONE: if (!md_if.ex_stall) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (md_if.ex_flush) begin
            w_state_next = S_IDLE;
            w_stall      = 1'b0;
        end
    end

    // State register and registered busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next inside {S_MUL1, S_MUL2, S_DIV, S_DFIX});
        end
    end

    // Operand capture, multiply/divide datapath and HI/LO writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_op_a  <= 33'd0;
            r_op_b  <= 33'd0;
            r_prod  <= 64'd0;
            r_rem   <= 32'd0;
            r_count <= 6'd0;
            r_op    <= 4'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            if (w_start) begin
                r_op <= md_if.ex_md_op;
                if (w_is_div) begin
                    r_op_a  <= {1'b0, w_abs_rs};
                    r_op_b  <= {1'b0, w_abs_rt};
                    r_rem   <= 32'd0;
                    r_count <= 6'd31;
                    // A zero divisor keeps the all-ones quotient un-negated
                    r_neg_q <= w_is_signed && (md_if.ex_data_rs[31] ^ md_if.ex_data_rt[31])
                               && (md_if.ex_data_rt != 32'd0);
                    r_neg_r <= w_is_signed && md_if.ex_data_rs[31];
                end else begin
                    r_op_a <= {w_is_signed & md_if.ex_data_rs[31], md_if.ex_data_rs};
                    r_op_b <= {w_is_signed & md_if.ex_data_rt[31], md_if.ex_data_rt};
                end
            end
            if (r_state == S_MUL1) r_prod <= w_mul_a * w_mul_b;
            if (r_state == S_DIV) begin
                r_rem         <= w_div_rem;
                r_op_a[31:0]  <= w_div_quo;
                r_count       <= r_count - 6'd1;
            end
            if (!md_if.ex_flush) begin
                if (r_state == S_MUL2) {r_hi, r_lo} <= w_mul_result;
                if (r_state == S_DFIX) begin
                    r_lo <= w_quo_fix;
                    r_hi <= w_rem_fix;
                end
                if (r_state == S_IDLE && md_if.ex_md_op == c_OP_MTHI) r_hi <= md_if.ex_data_rs;
                if (r_state == S_IDLE && md_if.ex_md_op == c_OP_MTLO) r_lo <= md_if.ex_data_rs;
            end
        end
    end

    assign md_if.md_hi    = r_hi;
    assign md_if.md_lo    = r_lo;
    assign md_if.md_stall = w_stall;
    assign md_if.md_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_antares_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_antares_ex_muldiv_unit
//  Purpose  : Self-checking bench for antares_ex_muldiv_unit; cycle-level
//             reference model plus directed literal checks and random ops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_antares_ex_muldiv_unit;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    antares_ex_muldiv_unit_if bus();
    antares_ex_muldiv_unit dut (.clk(clk), .rst(rst), .md_if(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
    logic [3:0]  m_op = 4'd0;
    int          m_mode = M_IDLE;
    int          m_left = 0;
    logic        exp_stall;

    function automatic bit is_mul(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic bit is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    // {HI,LO} produced by a finished op, from plain arithmetic
    function automatic logic [63:0] result(input logic [3:0] op, input logic [31:0] a, b,
                                           input logic [63:0] acc);
        logic [63:0] x, y, p;
        int sa, sb;
        logic [31:0] q, r;
        if (is_div(op)) begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (op == OP_DIV) begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
            end else begin
                q = a / b;
                r = a % b;
            end
            return {r, q};
        end
        if (op inside {OP_MULT, OP_MADD, OP_MSUB}) begin
            x = {{32{a[31]}}, a};
            y = {{32{b[31]}}, b};
        end else begin
            x = {32'd0, a};
            y = {32'd0, b};
        end
        p = x * y;
        if (op inside {OP_MADD, OP_MADDU}) return acc + p;
        if (op inside {OP_MSUB, OP_MSUBU}) return acc - p;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances one cycle per clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_mode <= M_IDLE;
            m_left <= 0;
        end else if (bus.ex_flush) begin
            m_mode <= M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (is_mul(bus.ex_md_op) || is_div(bus.ex_md_op)) begin
                        m_mode <= M_RUN;
                        m_left <= is_div(bus.ex_md_op) ? 33 : 2;
                        m_op   <= bus.ex_md_op;
                        m_a    <= bus.ex_data_rs;
                        m_b    <= bus.ex_data_rt;
                    end else if (bus.ex_md_op == OP_MTHI) begin
                        m_hi <= bus.ex_data_rs;
                    end else if (bus.ex_md_op == OP_MTLO) begin
                        m_lo <= bus.ex_data_rs;
                    end
                end
                M_RUN: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        {m_hi, m_lo} <= result(m_op, m_a, m_b, {m_hi, m_lo});
                        m_mode       <= M_DONE;
                    end
                end
                default: if (!bus.ex_stall) m_mode <= M_IDLE;
            endcase
        end
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        exp_stall = rst && !bus.ex_flush &&
                    (m_mode == M_RUN || (m_mode == M_IDLE && (is_mul(bus.ex_md_op) || is_div(bus.ex_md_op))));
        check("cyc_md_hi", bus.md_hi, m_hi);
        check("cyc_md_lo", bus.md_lo, m_lo);
        check("cyc_md_stall", {31'd0, bus.md_stall}, {31'd0, exp_stall});
        check("cyc_md_busy", {31'd0, bus.md_busy}, {31'd0, (m_mode == M_RUN)});
    end

    // Present an op until it leaves EX; hold = cycles of external EX stall
    task automatic do_op(input logic [3:0] op, input logic [31:0] rs, rt, input int hold,
                         output int stalls);
        bit leave;
        int n;
        stalls = 0;
        n      = 0;
        bus.ex_md_op  = op;
        bus.ex_data_rs = rs;
        bus.ex_data_rt = rt;
        bus.ex_stall  = (hold > 0);
        do begin
            @(negedge clk);
            if (bus.md_stall) stalls++;
            leave = !bus.md_stall && !bus.ex_stall;
            @(posedge clk);
            #1;
            n++;
            if (hold > 0) hold--;
            bus.ex_stall = (hold > 0);
        end while (!leave && n < 100);
        check("op_leaves_ex", {31'd0, leave}, 32'd1);
        bus.ex_md_op = OP_NONE;
    endtask

    // Present an op and kill it with a one-cycle flush k cycles after issue
    task automatic flush_op(input logic [3:0] op, input logic [31:0] rs, rt, input int k);
        bus.ex_md_op   = op;
        bus.ex_data_rs = rs;
        bus.ex_data_rt = rt;
        bus.ex_stall   = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        bus.ex_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.ex_flush = 1'b0;
        bus.ex_md_op = OP_NONE;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(1, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [3:0]  op;
        logic [31:0] a, b;
        bus.ex_md_op   = OP_NONE;
        bus.ex_data_rs = 32'd0;
        bus.ex_data_rt = 32'd0;
        bus.ex_flush   = 1'b0;
        bus.ex_stall   = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.md_hi, 32'h0);
        check("reset_lo", bus.md_lo, 32'h0);
        check("reset_busy", {31'd0, bus.md_busy}, 32'd0);
        check("reset_stall", {31'd0, bus.md_stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        do_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 0, st);
        check("mult_stall_cycles", st, 32'd3);
        check("mult_hi", bus.md_hi, 32'hFFFFFFFF);
        check("mult_lo", bus.md_lo, 32'hFFFFFFFA);

        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, st);
        check("multu_hi", bus.md_hi, 32'hFFFFFFFE);
        check("multu_lo", bus.md_lo, 32'h00000001);
        do_op(OP_MADDU, 32'd1, 32'd1, 0, st);
        check("maddu_hi", bus.md_hi, 32'hFFFFFFFE);
        check("maddu_lo", bus.md_lo, 32'h00000002);

        do_op(OP_MTHI, 32'd0, 32'd0, 0, st);
        do_op(OP_MTLO, 32'd0, 32'd0, 0, st);
        do_op(OP_MSUB, 32'd1, 32'd1, 0, st);
        check("msub_hi", bus.md_hi, 32'hFFFFFFFF);
        check("msub_lo", bus.md_lo, 32'hFFFFFFFF);

        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, st);
        check("div_stall_cycles", st, 32'd34);
        check("div_lo", bus.md_lo, 32'hFFFFFFFD);
        check("div_hi", bus.md_hi, 32'hFFFFFFFF);

        do_op(OP_DIVU, 32'd7, 32'd0, 0, st);
        check("divu0_lo", bus.md_lo, 32'hFFFFFFFF);
        check("divu0_hi", bus.md_hi, 32'd7);

        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, st);
        check("divovf_lo", bus.md_lo, 32'h80000000);
        check("divovf_hi", bus.md_hi, 32'h0);

        // Long external stall: exactly one result, no re-issue while DONE
        do_op(OP_DIV, 32'd5, 32'd3, 41, st);
        check("div_held_stall_cycles", st, 32'd34);
        check("div_held_lo", bus.md_lo, 32'd1);
        check("div_held_hi", bus.md_hi, 32'd2);

        flush_op(OP_DIV, 32'd100, 32'd7, 20);
        check("flush_div_busy", {31'd0, bus.md_busy}, 32'd0);
        check("flush_div_lo", bus.md_lo, 32'd1);
        check("flush_div_hi", bus.md_hi, 32'd2);

        flush_op(OP_MULT, 32'd9, 32'd9, 2);
        check("flush_mul2_busy", {31'd0, bus.md_busy}, 32'd0);
        check("flush_mul2_lo", bus.md_lo, 32'd1);
        check("flush_mul2_hi", bus.md_hi, 32'd2);

        do_op(OP_MTLO, 32'h1234, 32'd0, 0, st);
        check("mtlo_lo", bus.md_lo, 32'h1234);

        // Asynchronous reset in the middle of a divide
        bus.ex_md_op   = OP_DIV;
        bus.ex_data_rs = 32'd100;
        bus.ex_data_rt = 32'd7;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        check("rst_mid_hi", bus.md_hi, 32'h0);
        check("rst_mid_lo", bus.md_lo, 32'h0);
        check("rst_mid_busy", {31'd0, bus.md_busy}, 32'd0);
        check("rst_mid_stall", {31'd0, bus.md_stall}, 32'd0);
        bus.ex_md_op = OP_NONE;
        @(posedge clk);
        #1 rst = 1'b1;

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = rnd_val();
            b  = rnd_val();
            if ((is_mul(op) || is_div(op)) && $urandom_range(0, 6) == 0)
                flush_op(op, a, b, $urandom_range(0, is_div(op) ? 33 : 2));
            else
                do_op(op, a, b, $urandom_range(0, 3), st);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
